// File: rtl/frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_receiver_pkg
// Description : Shared FSM encoding, default geometry and RGB byte order.
// Revision    : 1.0
// ============================================================================
package frame_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RECV = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int c_DEFAULT_N = 450;
  localparam int c_DEFAULT_M = 450;

  localparam logic [1:0] c_PHASE_R = 2'd0;
  localparam logic [1:0] c_PHASE_G = 2'd1;
  localparam logic [1:0] c_PHASE_B = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_counter
// Description : Raster x/y counters with start/end-of-line/end-of-frame decode.
// Revision    : 1.0
// ============================================================================
module pixel_counter
  import frame_receiver_pkg::*;
#(
  parameter int N = c_DEFAULT_N,
  parameter int M = c_DEFAULT_M,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] x,
  output logic [RW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  logic [CW-1:0] r_x;
  logic [RW-1:0] r_y;

  assign x   = r_x;
  assign y   = r_y;
  assign sof = (r_x == '0) && (r_y == '0);
  assign eol = (r_x == CW'(N - 1));
  assign eof = eol && (r_y == RW'(M - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (eof) begin
        r_x <= '0;
        r_y <= '0;
      end else if (eol) begin
        r_x <= '0;
        r_y <= r_y + RW'(1);
      end else begin
        r_x <= r_x + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : frame_receiver
// Description : Captures one RGB888 byte-serial frame and streams out pixels.
// Revision    : 1.0
// ============================================================================
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int N = c_DEFAULT_N,
  parameter int M = c_DEFAULT_M,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          camera_en,
  input  logic          data_valid,
  input  logic [7:0]    data_in,
  output logic          pix_valid,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic [CW-1:0] pix_x,
  output logic [RW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int c_LAST_BYTE = 3 * N * M - 1;
  localparam int c_BYTE_W    = $clog2(c_LAST_BYTE + 1);

  state_t              r_state;
  logic [1:0]          r_phase;
  logic [c_BYTE_W-1:0] r_byte_cnt;
  logic [7:0]          r_red;
  logic [7:0]          r_green;

  logic          w_in_frame, w_accept, w_last, w_gap, w_can_start, w_pix_done, w_clear;
  logic [CW-1:0] w_x;
  logic [RW-1:0] w_y;
  logic          w_sof, w_eol, w_eof;

  assign w_in_frame  = (r_state == ST_ARM) || (r_state == ST_RECV);
  assign w_accept    = w_in_frame && data_valid && !abort;
  assign w_last      = w_accept && (r_byte_cnt == c_BYTE_W'(c_LAST_BYTE));
  assign w_gap       = (r_state == ST_RECV) && !data_valid && !abort;
  assign w_can_start = start && !abort && !w_in_frame;
  assign w_pix_done  = w_accept && (r_phase == c_PHASE_B);
  // Every exit from ARM/RECV, and every new capture, rewinds the raster.
  assign w_clear     = abort || w_gap || w_last || w_can_start;

  pixel_counter #(
    .N (N),
    .M (M)
  ) u_pixel_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .advance (w_pix_done),
    .x       (w_x),
    .y       (w_y),
    .sof     (w_sof),
    .eol     (w_eol),
    .eof     (w_eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      camera_en  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      r_phase    <= c_PHASE_R;
      r_byte_cnt <= '0;
      r_red      <= '0;
      r_green    <= '0;
      pix_valid  <= 1'b0;
      pix_r      <= '0;
      pix_g      <= '0;
      pix_b      <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;

      if (abort) begin
        r_state    <= ST_IDLE;
        camera_en  <= 1'b0;
        busy       <= 1'b0;
        err        <= 1'b0;
        r_phase    <= c_PHASE_R;
        r_byte_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
              r_state    <= ST_ARM;
              camera_en  <= 1'b1;
              busy       <= 1'b1;
              err        <= 1'b0;
              r_phase    <= c_PHASE_R;
              r_byte_cnt <= '0;
            end
          end
          ST_ARM: begin
            if (data_valid) r_state <= ST_RECV;
          end
          ST_RECV: begin
            if (!data_valid) begin
              r_state    <= ST_ERR;
              camera_en  <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
              r_phase    <= c_PHASE_R;
              r_byte_cnt <= '0;
            end else if (w_last) begin
              r_state   <= ST_DONE;
              camera_en <= 1'b0;
              busy      <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            camera_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end

      if (w_accept) begin
        r_byte_cnt <= w_last ? '0 : r_byte_cnt + c_BYTE_W'(1);
        case (r_phase)
          c_PHASE_R: begin
            r_red   <= data_in;
            r_phase <= c_PHASE_G;
          end
          c_PHASE_G: begin
            r_green <= data_in;
            r_phase <= c_PHASE_B;
          end
          default: begin
            r_phase    <= c_PHASE_R;
            pix_valid  <= 1'b1;
            pix_r      <= r_red;
            pix_g      <= r_green;
            pix_b      <= data_in;
            pix_x      <= w_x;
            pix_y      <= w_y;
            sof        <= w_sof;
            eol        <= w_eol;
            eof        <= w_eof;
            frame_done <= w_last;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter N, default 450, meaning pixels per line (columns).
REQ-002 SHALL have parameter M, default 450, meaning lines per frame (rows).
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to capture one frame; honoured only in IDLE, DONE or ERR.
REQ-006 SHALL have port abort  input  1  returns the FSM to IDLE from any state.
REQ-007 SHALL have port camera_en  output  1  registered enable to the pixel source.
REQ-008 SHALL have port data_valid  input  1  source byte strobe.
REQ-009 SHALL have port data_in  input  8  source byte; only sampled when data_valid=1.
REQ-010 SHALL have port pix_valid  output  1  one-cycle strobe per assembled pixel.
REQ-011 SHALL have port pix_r, pix_g, pix_b  output  8 each  assembled pixel components.
REQ-012 SHALL have port pix_x  output  CW  column of the current pixel, where CW = clog2(N).
REQ-013 SHALL have port pix_y  output  RW  row of the current pixel, where RW = clog2(M).
REQ-014 SHALL have port sof, eol, eof  output  1 each  qualifiers asserted together with pix_valid.
REQ-015 SHALL have port busy  output  1  high in ARM or RECV.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when a full frame completes.
REQ-017 SHALL have port err  output  1  sticky stream-gap error flag.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, RECV, DONE and ERR.
REQ-019 Transitions SHALL be: IDLE/DONE/ERR + start -> ARM; ARM -> RECV when the first data_valid arrives; RECV + last byte -> DONE; RECV + gap -> ERR; any state + abort -> IDLE (abort wins over start).
REQ-020 camera_en SHALL be 1 in ARM and RECV, and 0 in all other states; it SHALL assert one cycle after start is sampled.
REQ-021 Byte order SHALL be R, G, B per pixel, with pixels in raster order: x = 0..N-1, then y++.
REQ-022 A byte phase counter (0..2) SHALL advance on each accepted byte; R and G SHALL be held in registers.
REQ-023 pix_valid SHALL assert the cycle after the B byte is sampled (latency 1 from the third byte), carrying the held R and G, the captured B, and the current x,y.
REQ-024 sof SHALL be asserted for x=0,y=0; eol for x=N-1; eof for x=N-1,y=M-1.
REQ-025 On eol, x SHALL wrap to 0 and y SHALL increment; on eof, x and y SHALL both clear.
REQ-026 On accepting byte 3*N*M-1, the FSM SHALL enter DONE, and frame_done SHALL pulse in the same cycle as the eof pixel.
REQ-027 Bytes arriving outside ARM/RECV, including the source's trailing byte after camera_en falls, SHALL be discarded with no pix_valid.
REQ-028 A gap is data_valid=0 in RECV before the frame completes; a gap SHALL force ERR, set err, drop camera_en, and discard any partial pixel.
REQ-029 err SHALL clear only on start or abort; a start out of ERR SHALL re-capture from byte 0.
REQ-030 start and the last byte in the same cycle SHALL have start ignored (the FSM is in RECV).
REQ-031 Leaving ARM/RECV for any reason SHALL clear the phase counter, x and y.
REQ-032 The byte counter SHALL be wide enough for 3*N*M-1 with no wrap.

Reset
REQ-033 While rst_n=0 the FSM SHALL be IDLE, with every output 0, including pix_r/g/b, pix_x and pix_y.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately, dropping camera_en asynchronously.
REQ-035 Deassertion of rst_n SHALL be synchronised externally; the first active edge after it SHALL behave as IDLE.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the default N/M, and the byte-order constants (R=0, G=1, B=2).
REQ-037 The block SHALL use one sub-module, pixel_counter, holding the x/y raster counters and the sof/eol/eof decode, parameterised by N and M.
REQ-038 No frame memory SHALL be instantiated; pixels are emitted as a stream.

Verification
REQ-039 N=M=4, start, model source streaming 0x00,0x01,... -> 16 pix_valid pulses; pixel 0 = (00,01,02); pixel 15 = (2D,2E,2F) with eof; frame_done with pixel 15; camera_en low after.
REQ-040 Source output still high one cycle after camera_en falls (byte 0x30) -> no extra pix_valid, state DONE.
REQ-041 data_valid dropped after byte 7 -> err=1, state ERR, camera_en=0, 2 pixels emitted; then start -> err=0 and a full 16-pixel frame.
REQ-042 abort and start in the same cycle during RECV -> IDLE, camera_en=0, no frame_done.
REQ-043 rst_n pulsed low at pixel 5 -> all outputs 0 immediately; start afterwards -> sof on the first pixel, x=y=0.
REQ-044 Two back-to-back frames (start issued in DONE) -> eol on x=3 each row, y wraps, and the second frame is identical to the first.
